// File: rtl/jzjpcc_mem_arbiter_pkg.sv
// jzjpcc_pkg: response-FSM encoding and default starvation limit shared by the arbiter files.
package jzjpcc_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RESP_F = 2'd1, RESP_D = 2'd2} resp_e;
   localparam int STARVE_MAX_DEF = 3;
endpackage

// File: rtl/jzjpcc_mem_arbiter_if.sv
// jzjpcc_mem_arbiter_if: fetch/data requester ports and single-port SRAM bus of the arbiter.
interface jzjpcc_mem_arbiter_if #(parameter int ADDR_W = 12);
   logic              f_req, f_gnt, f_rvalid;
   logic [ADDR_W-1:0] f_addr;
   logic [31:0]       f_rdata;
   logic              d_req, d_we, d_gnt, d_rvalid;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata, d_rdata;
   logic [3:0]        d_bmask;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;
   logic [3:0]        ram_bmask;
   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_bmask, ram_rdata,
      output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
             ram_en, ram_we, ram_addr, ram_wdata, ram_bmask
   );
   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_bmask, ram_rdata,
      input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
             ram_en, ram_we, ram_addr, ram_wdata, ram_bmask
   );
endinterface

// File: rtl/jzjpcc_mem_arbiter_starve.sv
// jzjpcc_arb_starve: saturating count of data grants won while fetch waits; raises fetch override at the limit.
module jzjpcc_arb_starve #(parameter int STARVE_MAX = 3) (
   input  logic clk,
   input  logic rst_n,
   input  logic f_req,
   input  logic f_gnt,
   input  logic d_gnt,
   output logic f_over
);
   localparam int W = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
   logic [W-1:0] cnt;
   always_comb f_over = f_req && (cnt == W'(STARVE_MAX));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (!f_req || f_gnt) cnt <= '0;
      else if (d_gnt && cnt != W'(STARVE_MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/jzjpcc_mem_arbiter.sv
// jzjpcc_mem_arbiter: fetch/data arbiter for a single-port SRAM with starvation override.
// Grant counters exist only when JZJPCC_MEM_ARBITER_STATS_EN is defined.
module jzjpcc_mem_arbiter
   import jzjpcc_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   jzjpcc_mem_arbiter_if.slave   bus,
   output logic [31:0]           stat_f_grants,
   output logic [31:0]           stat_d_grants
);
   logic  f_over, f_gnt, d_gnt;
   resp_e state;
   jzjpcc_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk(clk), .rst_n(rst_n), .f_req(bus.f_req), .f_gnt(f_gnt), .d_gnt(d_gnt), .f_over(f_over)
   );
   // Reset gates the grants so nothing reaches the RAM while rst_n is low.
   always_comb begin
      f_gnt         = rst_n && bus.f_req && (!bus.d_req || f_over);
      d_gnt         = rst_n && bus.d_req && !f_over;
      bus.f_gnt     = f_gnt;
      bus.d_gnt     = d_gnt;
      bus.ram_en    = f_gnt || d_gnt;
      bus.ram_we    = d_gnt && bus.d_we;
      bus.ram_addr  = f_gnt ? bus.f_addr : d_gnt ? bus.d_addr : {ADDR_W{1'b0}};
      bus.ram_wdata = d_gnt ? bus.d_wdata : 32'd0;
      bus.ram_bmask = d_gnt ? bus.d_bmask : 4'd0;
      bus.f_rvalid  = state == RESP_F;
      bus.d_rvalid  = state == RESP_D;
      bus.f_rdata   = bus.ram_rdata;
      bus.d_rdata   = bus.ram_rdata;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= f_gnt ? RESP_F : (d_gnt && !bus.d_we) ? RESP_D : IDLE;
`ifdef JZJPCC_MEM_ARBITER_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stat_f_grants <= '0;
         stat_d_grants <= '0;
      end else begin
         stat_f_grants <= stat_f_grants + 32'(f_gnt);
         stat_d_grants <= stat_d_grants + 32'(d_gnt);
      end
`else
   assign stat_f_grants = '0;
   assign stat_d_grants = '0;
`endif
endmodule

// File: tb/tb_jzjpcc_mem_arbiter.sv
// tb_jzjpcc_mem_arbiter: directed checks of arbitration, starvation override, reads/writes, reset and stats.
module tb_jzjpcc_mem_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] stat_f, stat_d, stat_f_exp, stat_d_exp;
   logic [31:0] mem [0:15];
   int          tests = 0, fails = 0;
   jzjpcc_mem_arbiter_if #(.ADDR_W(12)) bus ();
   jzjpcc_mem_arbiter #(.ADDR_W(12), .STARVE_MAX(3)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .stat_f_grants(stat_f), .stat_d_grants(stat_d)
   );
   always #5 clk = ~clk;
   // SRAM model: one-cycle read latency, byte-masked writes
   always @(posedge clk)
      if (bus.ram_en) begin
         if (bus.ram_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.ram_bmask[b]) mem[bus.ram_addr[3:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
         end else bus.ram_rdata <= mem[bus.ram_addr[3:0]];
      end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
      bus.ram_rdata = '0;
      bus.f_req = 1; bus.f_addr = 12'd3; bus.d_req = 1; bus.d_we = 1;
      bus.d_addr = 12'd4; bus.d_wdata = 32'h1234_5678; bus.d_bmask = 4'hF;
      #2;
      chk("rst_f_gnt", bus.f_gnt, 0);
      chk("rst_d_gnt", bus.d_gnt, 0);
      chk("rst_ram_en", bus.ram_en, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_f_rvalid", bus.f_rvalid, 0);
      chk("rst_d_rvalid", bus.d_rvalid, 0);
      tick();
      chk("rst_stat_f", stat_f, 0);
      chk("rst_stat_d", stat_d, 0);
      bus.f_req = 0; bus.d_req = 0; bus.d_we = 0;
      rst_n = 1;
      tick();
      // single fetch read
      bus.f_req = 1; bus.f_addr = 12'd5;
      #2;
      chk("f_gnt", bus.f_gnt, 1);
      chk("f_d_gnt", bus.d_gnt, 0);
      chk("f_ram_en", bus.ram_en, 1);
      chk("f_ram_addr", bus.ram_addr, 5);
      chk("f_ram_bmask", bus.ram_bmask, 0);
      chk("f_ram_we", bus.ram_we, 0);
      tick();
      bus.f_req = 0;
      #2;
      chk("f_rvalid", bus.f_rvalid, 1);
      chk("f_rdata", bus.f_rdata, 32'h1000_0005);
      chk("f_d_rvalid", bus.d_rvalid, 0);
      chk("idle_ram_en", bus.ram_en, 0);
      chk("idle_ram_addr", bus.ram_addr, 0);
      tick();
      chk("f_rvalid_drop", bus.f_rvalid, 0);
      // masked data write
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 12'd2; bus.d_wdata = 32'hDEAD_BEEF; bus.d_bmask = 4'b0011;
      #2;
      chk("w_d_gnt", bus.d_gnt, 1);
      chk("w_ram_we", bus.ram_we, 1);
      chk("w_ram_bmask", bus.ram_bmask, 4'b0011);
      chk("w_ram_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
      chk("w_ram_addr", bus.ram_addr, 2);
      tick();
      bus.d_we = 0;
      #2;
      chk("w_no_rvalid", bus.d_rvalid, 0);
      chk("rd_ram_we", bus.ram_we, 0);
      tick();
      bus.d_req = 0;
      #2;
      chk("d_rvalid", bus.d_rvalid, 1);
      chk("d_rdata_merge", bus.d_rdata, 32'h1000_BEEF);
      tick();
      // contention: d, d, d, then forced f, then d
      bus.f_req = 1; bus.f_addr = 12'd7; bus.d_req = 1; bus.d_addr = 12'd9;
      for (int i = 0; i < 5; i++) begin
         #2;
         chk($sformatf("arb_f_gnt%0d", i), bus.f_gnt, i == 3);
         chk($sformatf("arb_d_gnt%0d", i), bus.d_gnt, i != 3);
         if (i == 1) chk("arb_d_rdata", bus.d_rdata, 32'h1000_0009);
         if (i == 4) chk("arb_f_rdata", bus.f_rdata, 32'h1000_0007);
         if (i > 0) chk($sformatf("arb_f_rvalid%0d", i), bus.f_rvalid, i == 4);
         if (i > 0) chk($sformatf("arb_d_rvalid%0d", i), bus.d_rvalid, i != 4);
         tick();
      end
      bus.f_req = 0; bus.d_req = 0;
      tick();
      // reset mid-read with starve count at 2
      bus.f_req = 1; bus.d_req = 1;
      tick();
      tick();
      #2;
      chk("pre_rst_d_gnt", bus.d_gnt, 1);
      chk("pre_rst_d_rvalid", bus.d_rvalid, 1);
      rst_n = 0;
      #1;
      chk("arst_d_rvalid", bus.d_rvalid, 0);
      chk("arst_f_rvalid", bus.f_rvalid, 0);
      chk("arst_d_gnt", bus.d_gnt, 0);
      chk("arst_ram_en", bus.ram_en, 0);
      tick();
      chk("arst_hold_d_rvalid", bus.d_rvalid, 0);
      chk("arst_stat_f", stat_f, 0);
      chk("arst_stat_d", stat_d, 0);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk($sformatf("post_rst_f_gnt%0d", i), bus.f_gnt, i == 3);
         tick();
      end
      bus.d_req = 0;
      for (int i = 0; i < 9; i++) tick();
      bus.f_req = 0; bus.d_req = 1;
      for (int i = 0; i < 4; i++) tick();
      bus.d_req = 0;
      #2;
`ifdef JZJPCC_MEM_ARBITER_STATS_EN
      stat_f_exp = 32'd10; stat_d_exp = 32'd7;
`else
      stat_f_exp = 32'd0; stat_d_exp = 32'd0;
`endif
      chk("stat_f_grants", stat_f, stat_f_exp);
      chk("stat_d_grants", stat_d, stat_d_exp);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
